// File: rtl/bf2i_pkg.sv
// bf2i_pkg - shared defaults and types for the BF2I bundle packer.
//   BF2I_WIDTH : default bit width of one signed R/Q sample
//   BF2I_DEPTH : default lanes per bundle (power of 2, >= 2)
//   LANE_W     : lane index width for the default depth
//   sample_t   : one signed sample
//   bundle_t   : DEPTH samples forming one bundle
package bf2i_pkg;

  localparam int BF2I_WIDTH = 9;
  localparam int BF2I_DEPTH = 16;
  localparam int LANE_W     = $clog2(BF2I_DEPTH);

  typedef logic signed [BF2I_WIDTH-1:0] sample_t;
  typedef sample_t [BF2I_DEPTH-1:0]     bundle_t;

endpackage

// File: rtl/bf2i_bundle_bank.sv
// bf2i_bundle_bank - one DEPTH-lane register bank of R/Q samples.
//   clk    : clock, rising edge
//   clr_i  : synchronous clear of every lane (dominates write)
//   we_i   : write enable
//   addr_i : lane to write
//   wr_r_i : real part to store
//   wr_q_i : imaginary part to store
//   rd_r_o : all real lanes, straight from registers
//   rd_q_o : all imaginary lanes, straight from registers
module bf2i_bundle_bank
  import bf2i_pkg::*;
#(
  parameter int WIDTH  = BF2I_WIDTH,
  parameter int DEPTH  = BF2I_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic signed [WIDTH-1:0] wr_r_i,
  input  logic signed [WIDTH-1:0] wr_q_i,
  output logic signed [WIDTH-1:0] rd_r_o [DEPTH],
  output logic signed [WIDTH-1:0] rd_q_o [DEPTH]
);

  logic signed [WIDTH-1:0] lane_r_q [DEPTH];
  logic signed [WIDTH-1:0] lane_q_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (clr_i) begin
          lane_r_q[gi] <= '0;
          lane_q_q[gi] <= '0;
        end else if (we_i && (addr_i == ADDR_W'(gi))) begin
          lane_r_q[gi] <= wr_r_i;
          lane_q_q[gi] <= wr_q_i;
        end
      end

      assign rd_r_o[gi] = lane_r_q[gi];
      assign rd_q_o[gi] = lane_q_q[gi];
    end
  endgenerate

endmodule

// File: rtl/bf2i_bundle_packer.sv
// bf2i_bundle_packer - packs serial complex samples into DEPTH-lane bundles
// for the BF2I butterfly, using two banks in ping-pong.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : sample handshake
//   in_sof              : start of frame, forces the sample into lane 0
//   in_R, in_Q          : signed sample
//   out_valid/out_ready : bundle handshake (out_valid feeds butterfly en)
//   dout_R, dout_Q      : bundle lanes of the presented bank
//   abort_flag          : sticky, set when in_sof truncates a partial bundle
module bf2i_bundle_packer
  import bf2i_pkg::*;
#(
  parameter int WIDTH = BF2I_WIDTH,
  parameter int DEPTH = BF2I_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic signed [WIDTH-1:0] in_R,
  input  logic signed [WIDTH-1:0] in_Q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] dout_R [DEPTH],
  output logic signed [WIDTH-1:0] dout_Q [DEPTH],
  output logic                    abort_flag
);

  localparam int LW = $clog2(DEPTH);

  logic [1:0]    full_q, full_d;
  logic          fill_sel_q, fill_sel_d;
  logic          out_sel_q, out_sel_d;
  logic [LW-1:0] wr_idx_q, wr_idx_d;
  logic          abort_q, abort_d;

  logic          acc;
  logic          rel;
  logic          last_lane;
  logic [LW-1:0] lane;

  logic signed [WIDTH-1:0] b0_r [DEPTH];
  logic signed [WIDTH-1:0] b0_q [DEPTH];
  logic signed [WIDTH-1:0] b1_r [DEPTH];
  logic signed [WIDTH-1:0] b1_q [DEPTH];

  // Ready depends only on registered state, so it never loops back on in_valid.
  assign in_ready  = !full_q[fill_sel_q];
  assign acc       = in_valid && in_ready;
  assign out_valid = full_q[out_sel_q];
  assign rel       = out_valid && out_ready;
  assign lane      = in_sof ? '0 : wr_idx_q;
  assign last_lane = acc && (lane == LW'(DEPTH - 1));

  always_comb begin
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    out_sel_d  = out_sel_q;
    wr_idx_d   = wr_idx_q;
    abort_d    = abort_q;

    if (acc) begin
      // Power-of-2 depth: lane+1 wraps to 0 after the last lane by itself.
      wr_idx_d = lane + 1'b1;
      if (in_sof && (wr_idx_q != '0)) begin
        abort_d = 1'b1;
      end
    end

    // Completion and release always target different banks (the fill bank
    // is never full while accepting), so both updates can apply together.
    if (last_lane) begin
      full_d[fill_sel_q] = 1'b1;
      fill_sel_d         = !fill_sel_q;
    end
    if (rel) begin
      full_d[out_sel_q] = 1'b0;
      out_sel_d         = !out_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      fill_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
      wr_idx_q   <= '0;
      abort_q    <= 1'b0;
    end else begin
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      out_sel_q  <= out_sel_d;
      wr_idx_q   <= wr_idx_d;
      abort_q    <= abort_d;
    end
  end

  assign abort_flag = abort_q;

  bf2i_bundle_bank #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (LW)
  ) u_bank0 (
    .clk    (clk),
    .clr_i  (rst),
    .we_i   (acc && !fill_sel_q),
    .addr_i (lane),
    .wr_r_i (in_R),
    .wr_q_i (in_Q),
    .rd_r_o (b0_r),
    .rd_q_o (b0_q)
  );

  bf2i_bundle_bank #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (LW)
  ) u_bank1 (
    .clk    (clk),
    .clr_i  (rst),
    .we_i   (acc && fill_sel_q),
    .addr_i (lane),
    .wr_r_i (in_R),
    .wr_q_i (in_Q),
    .rd_r_o (b1_r),
    .rd_q_o (b1_q)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_out
      assign dout_R[gi] = out_sel_q ? b1_r[gi] : b0_r[gi];
      assign dout_Q[gi] = out_sel_q ? b1_q[gi] : b0_q[gi];
    end
  endgenerate

endmodule

// File: doc/bf2i_bundle_packer.md
Name: bf2i_bundle_packer

Overview:
Serial-to-bundle front end for the BF2I butterfly stage. It accepts one complex sample (R/Q) per handshake and packs DEPTH consecutive samples into a DEPTH-lane bundle. Full bundles are presented with a valid/ready handshake; out_valid drives the butterfly's en. Two banks are used in ping-pong so input streaming does not stall while a bundle is being consumed.

Parameters:
WIDTH, 9, bit width of each signed R/Q sample; output lanes have the same width.
DEPTH, 16, lanes per bundle; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  sample present on in_R/in_Q.
in_ready  output  1  packer can accept a sample this cycle.
in_sof  input  1  start of frame; qualified by in_valid && in_ready; forces the sample into lane 0.
in_R  input  WIDTH signed  real part of the sample.
in_Q  input  WIDTH signed  imaginary part of the sample.
out_valid  output  1  complete bundle on dout_R/dout_Q; connects to the butterfly en.
out_ready  input  1  consumer takes the bundle this cycle.
dout_R  output  WIDTH signed x DEPTH unpacked array  real lanes; lane k is the k-th sample of the bundle.
dout_Q  output  WIDTH signed x DEPTH unpacked array  imaginary lanes.
abort_flag  output  1  sticky; set when in_sof truncates a partial bundle.

Behaviour:
- Storage: bank[0..1] of DEPTH R/Q registers; full[1:0]; fill_sel (bank being written); out_sel (bank being presented); lane counter wr_idx of log2(DEPTH) bits.
- Accept: acc = in_valid && in_ready, where in_ready = !full[fill_sel]. in_ready is combinational from registered state only and never depends on in_valid.
- On acc:
  - Lane index is 0 if in_sof, otherwise wr_idx.
  - bank[fill_sel][lane] <= {in_R, in_Q}.
  - wr_idx <= lane+1, wrapping to 0 after DEPTH-1.
- Completion: acc into lane DEPTH-1 sets full[fill_sel], toggles fill_sel, and resets wr_idx to 0.
- Output:
  - out_valid = full[out_sel].
  - dout_R/dout_Q show bank[out_sel] directly from registers.
  - When out_valid is 0, the outputs show the current out_sel bank contents; consumers must ignore them.
  - On out_valid && out_ready: clear full[out_sel] and toggle out_sel.
- Data stability: while out_valid=1 and out_ready=0, dout stays stable and out_valid stays high.
- Latency: out_valid rises on the first clock edge after the cycle that accepts lane DEPTH-1 (1 cycle).
- Throughput: one sample per cycle sustained when out_ready is held high; in_ready never drops.
- Backpressure:
  - When both banks are full, in_ready=0.
  - When out_ready frees a bank, in_ready returns on the next cycle.
- Same-cycle events:
  - Completion of one bank and output release of the other in the same cycle are both applied.
  - Completion and release of the same bank cannot coincide, because the fill bank is never full.
- in_sof:
  - When wr_idx != 0 at an accepted in_sof, the partial bundle is discarded: lanes are overwritten, not cleared. abort_flag <= 1.
  - When wr_idx == 0, in_sof is a no-op realignment.
  - in_sof with DEPTH==... not applicable: an accepted in_sof sample always lands in lane 0.
- No arithmetic: sample values pass through bit-exact with no sign extension or rounding.
- Reset (synchronous; rst dominates any concurrent handshake):
  - All bank registers 0, full=00, fill_sel=0, out_sel=0, wr_idx=0, abort_flag=0.
  - Resulting outputs: out_valid=0, in_ready=1, dout all 0.
  - Mid-operation reset discards all partial and pending bundles; the first sample after reset goes to lane 0.

Decomposition:
- Package bf2i_pkg holds:
  - WIDTH/DEPTH defaults.
  - LANE_W = $clog2(DEPTH).
  - typedef sample_t (logic signed [WIDTH-1:0]).
  - typedef bundle_t (sample_t [DEPTH-1:0]).
- One natural sub-module: bf2i_bundle_bank, a single DEPTH-lane register bank with write enable, lane address and synchronous clear, instantiated twice.
- The ping-pong control stays in the top.

Test Plan:
1. Reset, then stream samples R=k, Q=-k for k=0..15 with out_ready=1 -> out_valid=1 for exactly one cycle, 1 cycle after k=15; dout_R[k]=k and dout_Q[k]=-k.
2. Stream 48 back-to-back samples (R=0..47) with out_ready=1 -> in_ready never drops; three bundles appear with lanes starting at R=0, 16 and 32.
3. Hold out_ready=0 and stream 40 samples -> in_ready falls after sample 31 and both banks are held. Raise out_ready for 1 cycle -> bundle R=0..15 is released, and in_ready=1 on the next cycle.
4. Send 5 samples, then in_sof with R=100, then 15 more samples -> abort_flag=1; bundle lane 0=100 and lanes 1..15 are the following samples.
5. Send values -256 and 255 on every lane (WIDTH=9) -> dout values are bit-exact with no sign corruption.
6. Assert rst for 1 cycle while one bank is full and 7 lanes of the other bank are written -> out_valid=0, in_ready=1, dout=0. The next 16 samples form a clean bundle.
